// File: rtl/ctrl_pkg.sv
// Shared state encoding and decoder cycle-count constants for the multicycle sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_RETIRE,
        ST_HALT,
        ST_PAUSE
    } ctrl_state_e;

    localparam int PC_INC = 4;

    // EXEC cycles minus one, as produced by the decoder on cnt_set
    localparam logic [1:0] ADD_CNT  = 2'd0;
    localparam logic [1:0] SUB_CNT  = 2'd0;
    localparam logic [1:0] ADDI_CNT = 2'd0;
    localparam logic [1:0] LUI_CNT  = 2'd0;
    localparam logic [1:0] JAL_CNT  = 2'd1;
    localparam logic [1:0] SW_CNT   = 2'd1;
    localparam logic [1:0] LW_CNT   = 2'd2;

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// EXEC step counter: load clears the step and captures the limit; en advances until last.
module ctrl_step_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] limit,
    input  logic         en,
    output logic [W-1:0] step,
    output logic         last
);

    logic [W-1:0] r_step;
    logic [W-1:0] r_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step  <= '0;
            r_limit <= '0;
        end else if (load) begin
            r_step  <= '0;
            r_limit <= limit;
        end else if (en && (r_step != r_limit)) begin
            r_step  <= r_step + W'(1);
        end
    end

    assign step = r_step;
    assign last = (r_step == r_limit);

endmodule

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/RETIRE sequencer owning the PC.
// Define CTRL_SINGLE_STEP_EN to add step_req and a PAUSE state after every RETIRE.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              FETCH_TMO = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step_req,
`endif
    output logic            imem_req,
    input  logic            imem_ack,
    output logic [PC_W-1:0] imem_addr,
    output logic            ir_load,
    input  logic [1:0]      cnt_set,
    input  logic            stop,
    input  logic            ins_lw,
    input  logic            ins_sw,
    input  logic            ins_jal,
    input  logic            ins_wb,
    input  logic [PC_W-1:0] jal_off,
    output logic [1:0]      exec_step,
    output logic            mem_re,
    output logic            mem_we,
    output logic            reg_we,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    localparam int               TMO_W    = cnt_width(FETCH_TMO);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TMO - 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic             r_fault;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_lw;
    logic             r_sw;
    logic             r_jal;
    logic             r_wb;
    logic [PC_W-1:0]  r_jal_off;

    logic             w_restart;
    logic             w_tmo_hit;
    logic [PC_W-1:0]  w_pc_delta;
    logic [1:0]       w_step;
    logic             w_last;

    assign w_restart  = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);
    assign w_pc_delta = r_jal ? (r_jal_off << 1) : PC_W'(PC_INC);

    ctrl_step_counter #(
        .W (2)
    ) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (r_state == ST_DECODE),
        .limit (cnt_set),
        .en    (r_state == ST_EXEC),
        .step  (w_step),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                // an ack arriving on the timeout cycle still completes the fetch
                if (imem_ack)       w_state_nxt = ST_DECODE;
                else if (w_tmo_hit) w_state_nxt = ST_HALT;
            end
            ST_DECODE: w_state_nxt = stop ? ST_HALT : ST_EXEC;
            ST_EXEC:   if (w_last) w_state_nxt = ST_RETIRE;
            ST_RETIRE: begin
`ifdef CTRL_SINGLE_STEP_EN
                w_state_nxt = ST_PAUSE;
`else
                w_state_nxt = ST_FETCH;
`endif
            end
            ST_HALT:   if (start) w_state_nxt = ST_FETCH;
`ifdef CTRL_SINGLE_STEP_EN
            ST_PAUSE:  if (step_req) w_state_nxt = ST_FETCH;
`endif
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ack;
                busy     = 1'b1;
            end
            ST_DECODE: busy = 1'b1;
            ST_EXEC: begin
                busy   = 1'b1;
                mem_re = r_lw && (w_step == 2'd0);
                mem_we = r_sw && w_last;
                reg_we = r_wb && w_last;
            end
            ST_RETIRE: busy   = 1'b1;
            ST_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    // Decoder outputs are captured in DECODE so EXEC/RETIRE strobes depend only on registered state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_fault   <= 1'b0;
            r_tmo_cnt <= '0;
            r_lw      <= 1'b0;
            r_sw      <= 1'b0;
            r_jal     <= 1'b0;
            r_wb      <= 1'b0;
            r_jal_off <= '0;
        end else begin
            if (w_restart) begin
                r_pc    <= RESET_PC;
                r_fault <= 1'b0;
            end else if (r_state == ST_RETIRE) begin
                r_pc    <= r_pc + w_pc_delta;
            end else if ((r_state == ST_FETCH) && !imem_ack && w_tmo_hit) begin
                r_fault <= 1'b1;
            end

            if (r_state == ST_FETCH) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end

            if (r_state == ST_DECODE) begin
                r_lw      <= ins_lw;
                r_sw      <= ins_sw;
                r_jal     <= ins_jal;
                r_wb      <= ins_wb;
                r_jal_off <= jal_off;
            end
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign fault     = r_fault;
    assign exec_step = w_step;

endmodule
